// File: rtl/data_mem_banked_pkg.sv
// Shared types for the banked data memory: access sizes, sequencer states
// and the Thumb load/store opcode-group decoder.
package data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } mem_state_t;

  typedef struct packed {
    mem_size_t size;
    logic      sgn;
  } size_dec_t;

  // opcode is instr[15:9]; groups not listed below (SP-relative, PUSH/POP,
  // LDM/STM, word immediate) all move whole words.
  function automatic size_dec_t decode_size(input logic [6:0] opcode);
    size_dec_t d;
    d.size = SZ_WORD;
    d.sgn  = 1'b0;
    casez (opcode)
      7'b0101_000, 7'b0101_100: d.size = SZ_WORD;
      7'b0101_001, 7'b0101_101: d.size = SZ_HALF;
      7'b0101_010, 7'b0101_110: d.size = SZ_BYTE;
      7'b0101_011: begin
        d.size = SZ_BYTE;
        d.sgn  = 1'b1;
      end
      7'b0101_111: begin
        d.size = SZ_HALF;
        d.sgn  = 1'b1;
      end
      7'b0111_???: d.size = SZ_BYTE;
      7'b1000_???: d.size = SZ_HALF;
      default:     d.size = SZ_WORD;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/data_mem_banked_byte_lane_ram.sv
// One byte lane of the data memory: synchronous write, registered read.
module byte_lane_ram #(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // Storage is deliberately not reset; contents survive rst_n.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_banked.sv
// Four byte-lane banks behind a valid/ready port with lane steering, fault
// detection and a burst sequencer; one response per beat, one cycle later.
module data_mem_banked
  import data_mem_pkg::*;
#(
  parameter int DEPTH     = 2048,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [CNT_W-1:0]  req_count,
  input  logic [31:0]       req_wdata,
  output logic [CNT_W-1:0]  beat_idx,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_fault,
  output logic              rsp_last,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [ADDR_W-1:0] base_q;
  mem_size_t         size_q;
  logic              write_q, signed_q;
  logic [CNT_W-1:0]  count_q;
  logic              ready_q, busy_q;
  logic              rsp_valid_q, rsp_fault_q, rsp_last_q, rsp_load_q, rsp_signed_q;
  logic [1:0]        rsp_off_q;
  mem_size_t         rsp_size_q;

  logic [ADDR_W-1:0] cur_addr_s;
  mem_size_t         cur_size_s;
  logic              cur_write_s, cur_signed_s, issue_s, accept_s;
  logic [CNT_W-1:0]  cur_count_s;
  logic              fault_s, last_s;
  logic [3:0]        lane_en_s, lane_we_s;
  logic [31:0]       wdata_s, rd_word_s, shifted_s, load_s;
  logic [7:0]        rd_lane_s [4];

  // Select the beat issuing this cycle: live request in IDLE, latched burst otherwise.
  always_comb begin
    if (state_q == ST_BURST) begin
      cur_addr_s   = base_q + (ADDR_W'(beat_q) << 2);
      cur_size_s   = size_q;
      cur_write_s  = write_q;
      cur_signed_s = signed_q;
      cur_count_s  = count_q;
      issue_s      = rst_n;
    end else begin
      cur_addr_s   = req_addr;
      cur_size_s   = mem_size_t'(req_size);
      cur_write_s  = req_write;
      cur_signed_s = req_signed;
      cur_count_s  = req_count;
      issue_s      = req_valid & ready_q & rst_n;
    end
  end

  assign accept_s = issue_s & (state_q == ST_IDLE);

  // Alignment, range and count checks for the current beat.
  always_comb begin
    fault_s = 1'b0;
    case (cur_size_s)
      SZ_BYTE: fault_s = 1'b0;
      SZ_HALF: fault_s = cur_addr_s[0];
      SZ_WORD: fault_s = |cur_addr_s[1:0];
      default: fault_s = 1'b1;
    endcase
    fault_s = fault_s
            | ((cur_addr_s >> 2) >= ADDR_W'(DEPTH))
            | (cur_count_s == {CNT_W{1'b0}})
            | (cur_count_s > CNT_W'(MAX_BURST))
            | ((cur_count_s > CNT_W'(1)) & (cur_size_s != SZ_WORD));
    last_s = fault_s | (beat_q == (cur_count_s - CNT_W'(1)));
  end

  // Byte-lane steering: store data is replicated so each lane sees its byte.
  always_comb begin
    lane_en_s = 4'b0000;
    wdata_s   = 32'h0000_0000;
    case (cur_size_s)
      SZ_BYTE: begin
        lane_en_s = 4'b0001 << cur_addr_s[1:0];
        wdata_s   = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        lane_en_s = cur_addr_s[1] ? 4'b1100 : 4'b0011;
        wdata_s   = {2{req_wdata[15:0]}};
      end
      SZ_WORD: begin
        lane_en_s = 4'b1111;
        wdata_s   = req_wdata;
      end
      default: begin
        lane_en_s = 4'b0000;
        wdata_s   = 32'h0000_0000;
      end
    endcase
    lane_we_s = lane_en_s & {4{issue_s & cur_write_s & ~fault_s}};
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    byte_lane_ram #(.DEPTH(DEPTH)) u_ram (
      .clk_i   (clk),
      .we_i    (lane_we_s[g]),
      .addr_i  (cur_addr_s[IDX_W+1:2]),
      .wdata_i (wdata_s[8*g +: 8]),
      .rdata_o (rd_lane_s[g])
    );
  end

  // Sequencer next state: a burst ends on its final beat or on any faulting beat.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_s && !last_s) begin
          state_d = ST_BURST;
          beat_d  = CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
          beat_d  = {CNT_W{1'b0}};
        end
      end
      ST_BURST: begin
        if (last_s) begin
          state_d = ST_IDLE;
          beat_d  = {CNT_W{1'b0}};
        end else begin
          beat_d  = beat_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = {CNT_W{1'b0}};
      end
    endcase
  end

  // Sequencer, burst context and response pipeline registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      beat_q       <= {CNT_W{1'b0}};
      base_q       <= {ADDR_W{1'b0}};
      size_q       <= SZ_BYTE;
      write_q      <= 1'b0;
      signed_q     <= 1'b0;
      count_q      <= {CNT_W{1'b0}};
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_fault_q  <= 1'b0;
      rsp_last_q   <= 1'b0;
      rsp_load_q   <= 1'b0;
      rsp_signed_q <= 1'b0;
      rsp_off_q    <= 2'b00;
      rsp_size_q   <= SZ_BYTE;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      ready_q <= (state_d == ST_IDLE);
      busy_q  <= (state_d == ST_BURST);
      if (accept_s) begin
        base_q   <= req_addr;
        size_q   <= mem_size_t'(req_size);
        write_q  <= req_write;
        signed_q <= req_signed;
        count_q  <= req_count;
      end
      rsp_valid_q  <= issue_s;
      rsp_fault_q  <= issue_s & fault_s;
      rsp_last_q   <= issue_s & last_s;
      rsp_load_q   <= issue_s & ~cur_write_s & ~fault_s;
      rsp_signed_q <= cur_signed_s;
      rsp_off_q    <= cur_addr_s[1:0];
      rsp_size_q   <= cur_size_s;
    end
  end

  // Load alignment and extension from the registered bank outputs.
  always_comb begin
    rd_word_s = {rd_lane_s[3], rd_lane_s[2], rd_lane_s[1], rd_lane_s[0]};
    shifted_s = rd_word_s >> {rsp_off_q, 3'b000};
    case (rsp_size_q)
      SZ_BYTE: load_s = {{24{rsp_signed_q & shifted_s[7]}}, shifted_s[7:0]};
      SZ_HALF: load_s = {{16{rsp_signed_q & shifted_s[15]}}, shifted_s[15:0]};
      SZ_WORD: load_s = shifted_s;
      default: load_s = 32'h0000_0000;
    endcase
  end

  assign req_ready = ready_q & rst_n;
  assign busy      = busy_q;
  assign beat_idx  = beat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_data  = rsp_load_q ? load_s : 32'h0000_0000;

endmodule

// File: tb/tb_data_mem_banked.sv
// Scoreboard bench for data_mem_banked: a byte-array reference model predicts
// every response, and a negedge monitor checks them as they appear.
module tb_data_mem_banked;

  localparam int DEPTH     = 2048;
  localparam int ADDR_W    = 32;
  localparam int MAX_BURST = 8;
  localparam int CNT_W     = $clog2(MAX_BURST + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_write, req_signed;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [CNT_W-1:0]  req_count;
  logic [31:0]       req_wdata;
  logic [CNT_W-1:0]  beat_idx;
  logic              rsp_valid, rsp_fault, rsp_last, busy;
  logic [31:0]       rsp_data;

  data_mem_banked #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_count(req_count), .req_wdata(req_wdata),
    .beat_idx(beat_idx), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_fault(rsp_fault), .rsp_last(rsp_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    bit          fault;
    bit          last;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mdl [DEPTH*4];
  logic [31:0] wd_arr [16];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference behaviour of one beat: byte-addressed little-endian memory.
  function automatic void model_beat(input bit wr, input logic [1:0] sz, input bit sg,
                                     input logic [31:0] a, input int cnt, input int k,
                                     input logic [31:0] wd, output exp_t e, output bit cont);
    int nb;
    logic [31:0] v;
    bit flt;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    flt = ((a & 32'(nb - 1)) != 32'd0) || (a >= 32'(DEPTH * 4)) ||
          (cnt < 1) || (cnt > MAX_BURST) || (cnt > 1 && nb != 4);
    v = 32'd0;
    if (!flt) begin
      if (wr) begin
        for (int i = 0; i < nb; i++) mdl[a + 32'(i)] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) v = v | (32'(mdl[a + 32'(i)]) << (8 * i));
        if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      end
    end
    e.data  = wr ? 32'd0 : v;
    e.fault = flt;
    e.last  = flt || (k == cnt - 1);
    e.cyc   = 0;
    cont    = !e.last;
  endfunction

  // Monitor: every presented response must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual data=%h fault=%b last=%b required=no response", rsp_data, rsp_fault, rsp_last);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp", {rsp_data, 2'b00, rsp_fault, rsp_last, 16'(cyc)}, {e.data, 2'b00, e.fault, e.last, 16'(e.cyc)});
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL rsp_missing actual=no response required data=%h fault=%b last=%b at cycle %0d", e.data, e.fault, e.last, e.cyc);
    end
  end

  task automatic do_req(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] addr,
                        input int cnt, input bit use_exp = 1'b0, input logic [31:0] exp_val = 32'd0);
    exp_t e;
    bit   cont, burst;
    int   n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (req_ready !== 1'b1) begin
      chk("ready_timeout", {31'd0, req_ready}, 32'd1);
      return;
    end
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_count  = CNT_W'(cnt);
    req_wdata  = wd_arr[0];
    chk("beat_idx", 32'(beat_idx), 32'd0);
    model_beat(wr, sz, sg, addr, cnt, 0, wd_arr[0], e, cont);
    if (use_exp) e.data = exp_val;
    e.cyc = cyc + 1;
    exp_q.push_back(e);
    burst = cont;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; cont && k < cnt; k++) begin
      chk("beat_idx", 32'(beat_idx), 32'(k));
      chk("burst_ready", {31'd0, req_ready}, 32'd0);
      chk("burst_busy", {31'd0, busy}, 32'd1);
      req_wdata  = wd_arr[k];
      req_addr   = $urandom;
      req_size   = 2'($urandom_range(0, 3));
      req_write  = ~wr;
      req_count  = CNT_W'($urandom_range(0, 15));
      model_beat(wr, sz, sg, addr + 32'(4 * k), cnt, k, wd_arr[k], e, cont);
      e.cyc = cyc + 1;
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    if (burst) begin
      chk("post_burst_ready", {31'd0, req_ready}, 32'd1);
      chk("post_burst_busy", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    bit   cont;
    int   r, cnt, idx;
    logic [1:0] sz;
    logic [31:0] addr;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'd0; req_count = CNT_W'(1); req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'd0, req_ready}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_beat_idx", 32'(beat_idx), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_fault_last", {30'd0, rsp_fault, rsp_last}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

    // Fill the working window and the top two words with known data.
    for (int b = 0; b < 17; b++) begin
      for (int k = 0; k < 8; k++) wd_arr[k] = $urandom;
      do_req(1'b1, 2'd2, 1'b0, 32'(b * 32), 8);
    end
    wd_arr[0] = $urandom; wd_arr[1] = $urandom;
    do_req(1'b1, 2'd2, 1'b0, 32'((DEPTH - 2) * 4), 2);

    wd_arr[0] = 32'hDEAD_BEEF;
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 1);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 1, 1'b1, 32'hDEAD_BEEF);
    wd_arr[0] = 32'h0000_0080;
    do_req(1'b1, 2'd0, 1'b0, 32'h13, 1);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 1, 1'b1, 32'hFFFF_FF80);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 1, 1'b1, 32'h0000_0080);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 1, 1'b1, 32'h80AD_BEEF);
    do_req(1'b0, 2'd1, 1'b0, 32'h11, 1, 1'b1, 32'h0000_0000);
    wd_arr[0] = 32'h0000_1234;
    do_req(1'b1, 2'd1, 1'b0, 32'h11, 1);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 1, 1'b1, 32'h80AD_BEEF);
    for (int k = 0; k < 4; k++) wd_arr[k] = 32'(k + 1);
    do_req(1'b1, 2'd2, 1'b0, 32'h40, 4);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 4);
    do_req(1'b0, 2'd2, 1'b0, 32'((DEPTH - 2) * 4), 3);

    for (int t = 0; t < 300; t++) begin
      for (int k = 0; k < 16; k++) wd_arr[k] = $urandom;
      sz = 2'($urandom_range(0, 2));
      r  = $urandom_range(0, 99);
      if (r < 60) cnt = 1;
      else if (r < 82) begin cnt = $urandom_range(2, 8); sz = 2'd2; end
      else if (r < 90) begin cnt = $urandom_range(2, 8); sz = 2'($urandom_range(0, 1)); end
      else begin cnt = $urandom_range(0, 1) == 0 ? 0 : $urandom_range(9, 15); end
      idx  = $urandom_range(0, 119);
      addr = 32'(idx * 4) + ((sz == 2'd2 && $urandom_range(0, 3) != 0) ? 32'd0 : 32'($urandom_range(0, 3)));
      if ($urandom_range(0, 19) == 0) addr = 32'h0001_0000 + 32'($urandom_range(0, 4095));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, cnt);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    // Reset on beat 1 of a 4-beat store: later beats must never be written.
    for (int k = 0; k < 4; k++) wd_arr[k] = 32'hA5A5_0000 + 32'(k);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h200; req_count = CNT_W'(4); req_wdata = wd_arr[0];
    chk("rst_test_ready", {31'd0, req_ready}, 32'd1);
    model_beat(1'b1, 2'd2, 1'b0, 32'h200, 4, 0, wd_arr[0], e, cont);
    e.cyc = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_test_beat_idx", 32'(beat_idx), 32'd1);
    req_wdata = wd_arr[1];
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midburst_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midburst_rst_ready", {31'd0, req_ready}, 32'd0);
    chk("midburst_rst_busy", {31'd0, busy}, 32'd0);
    chk("midburst_rst_beat_idx", 32'(beat_idx), 32'd0);
    rst_n = 1'b1;
    req_wdata = wd_arr[2];
    @(posedge clk); #1;
    chk("release_ready", {31'd0, req_ready}, 32'd1);
    chk("release_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("release_busy", {31'd0, busy}, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h208, 1);
    do_req(1'b0, 2'd2, 1'b0, 32'h20C, 1);
    do_req(1'b0, 2'd2, 1'b0, 32'h200, 1);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
